// File: rtl/tx_frame_gen.sv
// Framed PN-symbol source (BPSK / QPSK / MIX) driving an AXI-Stream modulator input.
// Optional preamble at the start of every frame is enabled by defining TX_FRAME_GEN_PREAMBLE_EN.
module tx_frame_gen #(
    parameter int BYTES     = 1,
    parameter int FRAME_LEN = 64,
    parameter int HDR_LEN   = 8,
    parameter int PRE_LEN   = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           MODE_CTRL,
    output logic [BYTES*8-1:0]   data_tdata,
    output logic                 data_tvalid,
    input  logic                 data_tready,
    output logic                 data_tlast,
    output logic                 data_tuser,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 busy
);

`ifdef TX_FRAME_GEN_PREAMBLE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    localparam int PRE_N = PRE_EN ? PRE_LEN : 0;
    localparam int SW    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

    localparam logic [SW-1:0] PRE_END  = SW'(PRE_N - 1);
    localparam logic [SW-1:0] HDR_END  = SW'(PRE_N + HDR_LEN - 1);
    localparam logic [SW-1:0] LAST_IDX = SW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_PAY
    } state_t;

    typedef enum logic [1:0] {
        M_BPSK,
        M_QPSK,
        M_MIX
    } mode_t;

    state_t            state, state_nxt;
    mode_t             cur_mode, cur_mode_nxt, req_mode;
    logic [SW-1:0]     sym_cnt, sym_cnt_nxt;
    logic [4:0]        pn5, pn5_nxt;
    logic [3:0]        pn4, pn4_nxt;
    logic [CNT_W-1:0]  frame_cnt_nxt;
    logic [1:0]        sym;
    logic              sym_bpsk;
    logic              qpsk_beat;
    logic              accept;

    // x^5+x^3+1 Fibonacci, shift left, output taken from the MSB
    function automatic logic [4:0] pn5_step(input logic [4:0] s);
        return {s[3:0], s[4] ^ s[2]};
    endfunction

    // x^4+x^3+1 Fibonacci, shift left, output taken from the MSB
    function automatic logic [3:0] pn4_step(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic logic mode_legal(input logic [3:0] m);
        return (m == 4'b0001) || (m == 4'b0010) || (m == 4'b0100);
    endfunction

    function automatic mode_t decode_mode(input logic [3:0] m);
        case (m)
            4'b0010: return M_QPSK;
            4'b0100: return M_MIX;
            default: return M_BPSK;
        endcase
    endfunction

    function automatic state_t body_state(input mode_t m);
        return (m == M_MIX && HDR_LEN > 0) ? S_HDR : S_PAY;
    endfunction

    function automatic state_t first_state(input mode_t m);
        return PRE_EN ? S_PRE : body_state(m);
    endfunction

    assign accept      = data_tvalid & data_tready;
    assign data_tvalid = (state != S_IDLE);
    assign busy        = (state != S_IDLE);
    assign data_tlast  = (state == S_PAY) && (sym_cnt == LAST_IDX);
    assign data_tuser  = sym_bpsk;
    assign data_tdata  = {{(BYTES*8-2){1'b0}}, sym};

    // Symbol mapping is a pure function of state, so a stalled beat stays put
    always_comb begin
        sym       = 2'b00;
        sym_bpsk  = 1'b0;
        qpsk_beat = 1'b0;
        case (state)
            S_PRE: begin
                sym      = {~sym_cnt[0], 1'b0};
                sym_bpsk = 1'b1;
            end
            S_HDR: begin
                sym      = {pn5[4], 1'b0};
                sym_bpsk = 1'b1;
            end
            S_PAY: begin
                if (cur_mode == M_BPSK) begin
                    sym      = {pn5[4], 1'b0};
                    sym_bpsk = 1'b1;
                end else begin
                    sym       = {pn5[4], pn4[3]};
                    qpsk_beat = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        cur_mode_nxt  = cur_mode;
        sym_cnt_nxt   = sym_cnt;
        pn5_nxt       = pn5;
        pn4_nxt       = pn4;
        frame_cnt_nxt = frame_cnt;
        req_mode      = decode_mode(MODE_CTRL);

        if (state == S_IDLE) begin
            if (mode_legal(MODE_CTRL)) begin
                cur_mode_nxt = req_mode;
                state_nxt    = first_state(req_mode);
                sym_cnt_nxt  = '0;
            end
        end else if (accept) begin
            sym_cnt_nxt = sym_cnt + 1'b1;
            // Preamble beats carry a fixed pattern and leave both generators untouched
            if (state != S_PRE) begin
                pn5_nxt = pn5_step(pn5);
            end
            if (qpsk_beat) begin
                pn4_nxt = pn4_step(pn4);
            end
            case (state)
                S_PRE: begin
                    if (sym_cnt == PRE_END) begin
                        state_nxt = body_state(cur_mode);
                    end
                end
                S_HDR: begin
                    if (sym_cnt == HDR_END) begin
                        state_nxt = S_PAY;
                    end
                end
                S_PAY: begin
                    if (sym_cnt == LAST_IDX) begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                        sym_cnt_nxt   = '0;
                        if (mode_legal(MODE_CTRL)) begin
                            cur_mode_nxt = req_mode;
                            state_nxt    = first_state(req_mode);
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_mode  <= M_BPSK;
            sym_cnt   <= '0;
            pn5       <= 5'b00001;
            pn4       <= 4'b0001;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cur_mode  <= cur_mode_nxt;
            sym_cnt   <= sym_cnt_nxt;
            pn5       <= pn5_nxt;
            pn4       <= pn4_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

endmodule
